// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator datapath (divider and friends).
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;

  // Quotient reported on divide-by-zero at the default width
  localparam logic [DEF_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_sub_stage.sv
// Combinational WIDTH+1-bit trial subtractor (minuend - subtrahend) with borrow output.
module div_sub_stage
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  logic [WIDTH+1:0] carry;

  // Two's complement subtract: invert subtrahend, carry-in of one
  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (minuend[i]),
      .b    (~subtrahend[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  assign borrow = ~carry[WIDTH+1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the calculator add/subtract paths.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/divider_4bit_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIVIDER_SIGNED_EN for two's complement operands (truncating division).
module divider_4bit_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] prem, q, dvsr;
  logic [WIDTH:0]   shifted, trial;
  logic             borrow;
  logic [WIDTH-1:0] prem_nxt, q_nxt;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] q_res, r_res;
  logic             unused_trial_msb;

  assign shifted = {prem, q[WIDTH-1]};

  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .minuend    (shifted),
    .subtrahend ({1'b0, dvsr}),
    .diff       (trial),
    .borrow     (borrow)
  );

  // prem < divisor always holds, so the kept/trial value fits in WIDTH bits
  assign prem_nxt         = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_nxt            = {q[WIDTH-2:0], ~borrow};
  assign unused_trial_msb = trial[WIDTH];

`ifdef DIVIDER_SIGNED_EN
  logic neg_q, neg_r;

  assign dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
  assign q_res   = neg_q ? (~q_nxt + 1'b1) : q_nxt;
  assign r_res   = neg_r ? (~prem_nxt + 1'b1) : prem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_res   = q_nxt;
  assign r_res   = prem_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = (divisor == '0) ? DONE : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      prem        <= '0;
      q           <= '0;
      dvsr        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt         <= CNT_W'(WIDTH - 1);
      prem        <= '0;
      q           <= dvd_mag;
      dvsr        <= dvs_mag;
      div_by_zero <= 1'b0;
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      prem <= prem_nxt;
      q    <= q_nxt;
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        quotient  <= q_res;
        remainder <= r_res;
      end
    end
  end

endmodule

// File: tb/tb_divider_4bit_seq.sv
// Self-checking bench for divider_4bit_seq: directed cases plus random operands vs an arithmetic model.
module tb_divider_4bit_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  divider_4bit_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int sa, sb;
    z = (b == '0);
    if (z) begin
      q = '1;
      r = a;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'(a);
      sb = int'(b);
`endif
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endtask

  // Called at a negedge with the DUT in IDLE or DONE. poke drives a rival request during RUN;
  // chain leaves the bench at the done negedge so the next call can start from DONE.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke, input bit chain);
    logic [W-1:0] eq, er;
    logic ez;
    int lat, k, busy_cyc;
    bit seen;
    model(a, b, eq, er, ez);
    lat = ez ? 0 : W;
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
    busy_cyc = 0;
    seen = 1'b0;
    for (k = 0; k < 20; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
      if (poke) begin
        start = (k < 2);
        dividend = 4'd1;
        divisor = 4'd1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check($sformatf("done_seen %0d/%0d", a, b), 32'(seen), 32'd1);
    if (seen) begin
      check($sformatf("latency %0d/%0d", a, b), 32'(k), 32'(lat));
      check($sformatf("busy_cycles %0d/%0d", a, b), 32'(busy_cyc), 32'(lat));
      check($sformatf("quotient %0d/%0d", a, b), 32'(quotient), 32'(eq));
      check($sformatf("remainder %0d/%0d", a, b), 32'(remainder), 32'(er));
      check($sformatf("div_by_zero %0d/%0d", a, b), 32'(div_by_zero), 32'(ez));
    end
    if (!chain) begin
      @(negedge clk);
      check("done_single_pulse", 32'(done), 32'd0);
      check("held_quotient", 32'(quotient), 32'(eq));
    end
  endtask

  initial begin
    int done_hits;
    logic [W-1:0] ra, rb;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(4'd13, 4'd3, 1'b0, 1'b0);
    do_op(4'd15, 4'd1, 1'b0, 1'b0);
    do_op(4'd5, 4'd7, 1'b0, 1'b0);
    do_op(4'd0, 4'd9, 1'b0, 1'b0);
    do_op(4'd9, 4'd0, 1'b0, 1'b0);
    do_op(4'd8, 4'd2, 1'b0, 1'b0);

    do_op(4'd12, 4'd5, 1'b1, 1'b1);
    do_op(4'd7, 4'd2, 1'b0, 1'b0);

`ifdef DIVIDER_SIGNED_EN
    do_op(4'h9, 4'd2, 1'b0, 1'b0);
    do_op(4'd7, 4'hE, 1'b0, 1'b0);
    do_op(4'h8, 4'hF, 1'b0, 1'b0);
`endif

    // Reset in the middle of 14/3; previous results are nonzero so the clear is visible
    start = 1'b1;
    dividend = 4'd14;
    divisor = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    done_hits = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_hits++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_hits++;
    end
    check("midrst_no_done", 32'(done_hits), 32'd0);
    do_op(4'd6, 4'd4, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 4'd0 : W'($urandom);
      do_op(ra, rb, ($urandom_range(0, 3) == 0) && (rb != 0), ($urandom_range(0, 2) == 0));
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
